// File: rtl/serial_interp_fir.sv
// serial_interp_fir: serial-MAC polyphase interpolating FIR, one multiply per clk (saturating accumulate under SERIAL_INTERP_FIR_SAT_EN)
module serial_interp_fir #(
  parameter int IN_W   = 8,
  parameter int COEF_W = 8,
  parameter int L      = 4,
  parameter int TPP    = 6,
  parameter int ACC_W  = 20,
  localparam int NTAPS = L * TPP,
  localparam int AW    = NTAPS > 1 ? $clog2(NTAPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IN_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     busy
);
  localparam int KW = TPP > 1 ? $clog2(TPP) : 1;
  localparam int PW = L > 1 ? $clog2(L) : 1;
  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;
  state_t state, state_nxt;
  logic signed [IN_W-1:0] d [TPP];
  logic signed [COEF_W-1:0] h [NTAPS];
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic signed [IN_W+COEF_W-1:0] prod;
  logic signed [ACC_W:0] sum;
  logic [KW-1:0] k;
  logic [PW-1:0] phase;
  logic [AW-1:0] idx;
  logic last_k, last_p, addr_ok;
  assign idx = AW'(int'(k) * L + int'(phase));
  assign prod = d[k] * h[idx];
  assign sum = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
`ifdef SERIAL_INTERP_FIR_SAT_EN
  assign acc_nxt = (sum[ACC_W] != sum[ACC_W-1]) ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif
  assign last_k = k == KW'(TPP - 1);
  assign last_p = phase == PW'(L - 1);
  assign addr_ok = {1'b0, coef_addr} < (AW+1)'(NTAPS);
  assign busy = state != IDLE;
  assign in_ready = state == IDLE && !rst;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  // next-state: IDLE -> MAC on a sample, MAC -> HOLD after the last tap, HOLD -> next phase or IDLE on handshake
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (in_valid ? MAC : IDLE) :
                state == MAC  ? (last_k ? HOLD : MAC) :
                out_ready     ? (last_p ? IDLE : MAC) : HOLD;
  end
  // datapath: coefficient writes and delay-line shift in IDLE, accumulate in MAC, output hold in HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TPP; i++) d[i] <= '0;
      for (int i = 0; i < NTAPS; i++) h[i] <= '0;
      acc <= '0;
      k <= '0;
      phase <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (coef_we && addr_ok) h[coef_addr] <= coef_data;
          if (in_valid) begin
            for (int i = TPP - 1; i > 0; i--) d[i] <= d[i-1];
            d[0] <= in_data;
            phase <= '0;
            k <= '0;
            acc <= '0;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          k <= last_k ? '0 : k + 1'b1;
          if (last_k) begin
            out_data <= acc_nxt;
            out_valid <= 1'b1;
          end
        end
        default: if (out_ready) begin
          out_valid <= 1'b0;
          if (!last_p) begin
            phase <= phase + 1'b1;
            k <= '0;
            acc <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_interp_fir.sv
// tb_serial_interp_fir: directed self-checking bench for serial_interp_fir (ACC_W=20 and ACC_W=16 instances)
module tb_serial_interp_fir;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1, coef_we = 1'b0;
  logic signed [7:0] in_data = '0, coef_data = '0;
  logic [4:0] coef_addr = '0;
  logic in_ready, out_valid, busy, in_ready_b, out_valid_b, busy_b;
  logic signed [19:0] out_data;
  logic signed [15:0] out_data_b;
  logic signed [19:0] ya [4];
  logic signed [15:0] yb [4];
  int n_cmp = 0, n_fail = 0, lat = 0;
`ifdef SERIAL_INTERP_FIR_SAT_EN
  localparam logic signed [15:0] EXP_B5 = 16'sd32767, EXP_B6 = 16'sd32767;
`else
  localparam logic signed [15:0] EXP_B5 = 16'sd15109, EXP_B6 = 16'sd31238;
`endif
  always #5 clk = ~clk;
  serial_interp_fir u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy));
  serial_interp_fir #(.ACC_W(16)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy_b));

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic load_coefs(input int mode);
    for (int n = 0; n < 24; n++) begin
      coef_we = 1'b1;
      coef_addr = 5'(n);
      coef_data = mode == 0 ? 8'(n + 1) : 8'sd127;
      @(posedge clk); #1;
    end
    coef_we = 1'b0;
  endtask

  task automatic send(input logic signed [7:0] x);
    int cnt = 0;
    while (!in_ready && cnt < 60) begin @(posedge clk); #1; cnt++; end
    n_cmp++;
    if (!in_ready) begin n_fail++; $display("FAIL send_timeout: in_ready=%0b required 1", in_ready); end
    in_valid = 1'b1;
    in_data = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int p);
    int cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!out_valid && cnt < 60);
    lat = cnt;
    n_cmp++;
    if (!out_valid) begin n_fail++; $display("FAIL out_timeout: out_valid=%0b required 1", out_valid); end
    ya[p] = out_data;
    yb[p] = out_data_b;
  endtask

  task automatic run_sample(input logic signed [7:0] x);
    send(x);
    for (int p = 0; p < 4; p++) wait_out(p);
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    do_reset();
    rst = 1'b1;
    n_cmp += 4;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    if (out_data !== 20'sd0) begin n_fail++; $display("FAIL rst_out_data: got %0d required 0", out_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %0b required 1", in_ready); end
  endtask

  task automatic test_impulse();
    do_reset();
    load_coefs(0);
    out_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      send(s == 0 ? 8'sd1 : 8'sd0);
      for (int p = 0; p < 4; p++) begin
        wait_out(p);
        if (s == 0 && p == 0) begin
          n_cmp++;
          if (lat !== 6) begin n_fail++; $display("FAIL impulse_latency: got %0d required 6", lat); end
        end
        n_cmp++;
        if (ya[p] !== 20'(4 * s + p + 1)) begin
          n_fail++; $display("FAIL impulse_s%0d_p%0d: got %0d required %0d", s, p, ya[p], 4 * s + p + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [19:0] held;
    do_reset();
    load_coefs(0);
    out_ready = 1'b0;
    send(8'sd2);
    wait_out(0);
    held = ya[0];
    n_cmp++;
    if (held !== 20'sd2) begin n_fail++; $display("FAIL bp_p0: got %0d required 2", held); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_cmp += 4;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d: got %0b required 1", c, out_valid); end
      if (out_data !== 20'sd2) begin n_fail++; $display("FAIL bp_data_c%0d: got %0d required 2", c, out_data); end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %0b required 0", c, in_ready); end
      if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy_c%0d: got %0b required 1", c, busy); end
    end
    out_ready = 1'b1;
    for (int p = 1; p < 4; p++) begin
      wait_out(p);
      n_cmp++;
      if (ya[p] !== 20'(2 * (p + 1))) begin n_fail++; $display("FAIL bp_p%0d: got %0d required %0d", p, ya[p], 2 * (p + 1)); end
    end
  endtask

  task automatic test_coef_write();
    do_reset();
    load_coefs(0);
    out_ready = 1'b1;
    send(8'sd3);
    coef_we = 1'b1; coef_addr = 5'd0; coef_data = 8'sd50;
    @(posedge clk); #1;
    coef_we = 1'b0;
    for (int p = 0; p < 4; p++) begin
      wait_out(p);
      n_cmp++;
      if (ya[p] !== 20'(3 * (p + 1))) begin n_fail++; $display("FAIL cw_mac_p%0d: got %0d required %0d", p, ya[p], 3 * (p + 1)); end
    end
    coef_we = 1'b1; coef_addr = 5'd0; coef_data = 8'sd50;
    send(8'sd1);
    coef_we = 1'b0;
    wait_out(0);
    wait_out(1);
    n_cmp += 2;
    if (ya[0] !== 20'sd65) begin n_fail++; $display("FAIL cw_idle_p0: got %0d required 65", ya[0]); end
    if (ya[1] !== 20'sd20) begin n_fail++; $display("FAIL cw_idle_p1: got %0d required 20", ya[1]); end
    wait_out(2);
    wait_out(3);
  endtask

  task automatic test_dc_overflow();
    do_reset();
    load_coefs(1);
    out_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      run_sample(8'sd127);
      if (s == 4) begin
        n_cmp += 2;
        if (ya[0] !== 20'sd80645) begin n_fail++; $display("FAIL dc5_a: got %0d required 80645", ya[0]); end
        if (yb[0] !== EXP_B5) begin n_fail++; $display("FAIL dc5_b: got %0d required %0d", yb[0], EXP_B5); end
      end
    end
    for (int p = 0; p < 4; p++) begin
      n_cmp += 2;
      if (ya[p] !== 20'sd96774) begin n_fail++; $display("FAIL dc6_a_p%0d: got %0d required 96774", p, ya[p]); end
      if (yb[p] !== EXP_B6) begin n_fail++; $display("FAIL dc6_b_p%0d: got %0d required %0d", p, yb[p], EXP_B6); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    load_coefs(0);
    out_ready = 1'b1;
    send(8'sd1);
    wait_out(0);
    wait_out(1);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_out_valid: got %0b required 0", out_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy: got %0b required 0", busy); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mr_in_ready: got %0b required 0", in_ready); end
    rst = 1'b0;
    run_sample(8'sd1);
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (ya[p] !== 20'sd0) begin n_fail++; $display("FAIL mr_zero_p%0d: got %0d required 0", p, ya[p]); end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_backpressure();
    test_coef_write();
    test_dc_overflow();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_interp_fir.md
Name: serial_interp_fir

Overview:
Single-clock serial-MAC interpolating FIR: accepts one signed sample, emits L filtered output samples (polyphase, zero-stuffing implied). One multiplier is time-shared across taps, one multiply per clk. Sits on the transmit/upsampling side of the AM chain, opposite the decimating/receive-side serial FIR. Valid/ready on both streams; coefficients are loaded through a write port.

Parameters:
IN_W, 8, input sample and delay-line width (signed)
COEF_W, 8, coefficient width (signed)
L, 4, interpolation factor (number of polyphase branches)
TPP, 6, taps per phase; total coefficients NTAPS = L*TPP
ACC_W, 20, accumulator and output width (signed); must be >= IN_W+COEF_W

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  IN_W  signed input sample
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_data  out  ACC_W  signed filtered output
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(NTAPS)  coefficient index n
coef_data  in  COEF_W  signed coefficient h[n]
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE; delay line d[0..TPP-1]=0; all h[n]=0; acc=0; phase=0; k=0; out_valid=0; out_data=0; in_ready=0 while rst high, and 1 on the first cycle after release.
- States: IDLE, MAC, HOLD.
- IDLE: in_ready=1. On in_valid: shift d[k]<=d[k-1], d[0]<=in_data; phase<=0; k<=0; acc<=0; go to MAC.
- MAC: each cycle acc<=acc+d[k]*h[k*L+phase]; k++. On k==TPP-1: out_data<=final sum including that product; out_valid<=1; go to HOLD. One phase = TPP MAC cycles.
- HOLD: out_valid=1, out_data stable until out_ready. On handshake: out_valid<=0. If phase==L-1, go to IDLE; else phase++, k<=0, acc<=0, go to MAC.
- Output for phase p: y_p = sum over k=0..TPP-1 of d[k]*h[k*L+p]. Outputs are emitted in order p=0..L-1.
- Latency: sample accepted at edge N; first out_valid visible after edge N+TPP.
- Throughput with out_ready tied high: one input per L*(TPP+1)+1 cycles.
- Arithmetic: product is IN_W+COEF_W signed, sign-extended to ACC_W. Accumulation wraps two's-complement (default build). No rounding or truncation.
- Coefficient writes: taken only in IDLE with coef_we=1, h[coef_addr]<=coef_data. Ignored outside IDLE. coef_addr >= NTAPS is ignored.
- Simultaneous coef_we and in_valid in IDLE: the coefficient write lands first and is used by the sample being accepted.
- rst mid-operation: aborts immediately and returns to the full reset state. The pending output is dropped and coefficients are cleared.
- out_ready high while out_valid low: no effect.
- in_valid while not IDLE: ignored; the upstream holds the sample.

Optional Feature:
SERIAL_INTERP_FIR_SAT_EN: when defined, each accumulator add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1] instead of wrapping, and a saturated partial sum stays clamped through later adds. When undefined, accumulation wraps modulo 2^ACC_W. Latency and handshake are identical in both builds.

Test Plan:
- Impulse, defaults, h[n]=n+1 for n=0..23, out_ready=1, inputs 1,0,0 -> outputs 1,2,3,4 then 5,6,7,8 then 9,10,11,12; first out_valid after edge N+6.
- DC, all h=127, TPP=6, input 127 held for 6 samples -> from the 6th sample, every phase outputs 96774.
- Overflow with ACC_W=16, all h=127, input 127 x6 -> 6th-sample outputs 31238 without the macro, 32767 with SERIAL_INTERP_FIR_SAT_EN.
- Backpressure: out_ready low for 10 cycles in HOLD -> out_valid stays 1, out_data unchanged, in_ready=0, busy=1; resumes correctly after out_ready rises.
- Coefficient write during MAC, h[0] 1->50 -> h[0] unchanged and the current sample's outputs still use 1; the same write in IDLE -> next sample's phase-0 output uses 50.
- rst asserted at k=3 of phase 2 -> next cycle out_valid=0, busy=0, in_ready=0; after release, impulse response is all zeros until coefficients are reloaded.
